comb_bist_ctrl: RTL

- Built-in self-test sequencer for a combinational netlist built from the NOT1/NAND2/NOR2 cell set.
- Upstream side: an LFSR drives pseudo-random patterns onto the netlist inputs.
- Downstream side: a MISR compacts the netlist outputs after a programmable settle time.
- Sits between the test controller and the cell-level netlist under test (NUT); one run per START pulse.

---
 rtl/comb_bist_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/comb_bist_ctrl.sv
// LFSR/MISR BIST sequencer for a combinational netlist under test.
// Define GOLDEN_CMP_EN to add the golden-signature comparator (golden_i / pass_o).
module comb_bist_ctrl #(
  parameter int unsigned     IN_W   = 8,
  parameter int unsigned     OUT_W  = 4,
  parameter int unsigned     NPAT   = 255,
  parameter int unsigned     SETTLE = 2,
  parameter logic [IN_W-1:0] SEED   = IN_W'(1),
  parameter logic [IN_W-1:0] POLY   = IN_W'(8'hB8),
  parameter logic [OUT_W-1:0] POLY_M = OUT_W'(4'hC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [OUT_W-1:0] resp_i,
`ifdef GOLDEN_CMP_EN
  input  logic [OUT_W-1:0] golden_i,
  output logic             pass_o,
`endif
  output logic [IN_W-1:0]  pat_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] sig_o,
  output logic [15:0]      pcnt_o
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [15:0] PatLast = 16'(NPAT);

  typedef enum logic [1:0] {StIdle, StHold, StCapture, StFin} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  pat_q, pat_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [IN_W-1:0]  lfsr_next;
  logic [OUT_W-1:0] misr_next;

  assign lfsr_next = {pat_q[IN_W-2:0], ^(pat_q & POLY)};
  assign misr_next = {sig_q[OUT_W-2:0], ^(sig_q & POLY_M)} ^ resp_i;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sig_d   = sig_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          pat_d   = SEED;
          sig_d   = '0;
          pcnt_d  = '0;
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == CntLast) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCapture: begin
        sig_d  = misr_next;
        pcnt_d = pcnt_q + 16'd1;
        // The last pattern is left on the NUT; the LFSR only steps between patterns.
        if (pcnt_d == PatLast) begin
          state_d = StFin;
        end else begin
          pat_d   = lfsr_next;
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pat_q   <= SEED;
      sig_q   <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sig_q   <= sig_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef GOLDEN_CMP_EN
  logic pass_q, pass_d;

  always_comb begin
    pass_d = pass_q;
    if (state_q == StIdle && start_i) begin
      pass_d = 1'b0;
    end else if (state_q == StFin) begin
      pass_d = (sig_q == golden_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign pass_o = pass_q;
`endif

  assign pat_o  = pat_q;
  assign sig_o  = sig_q;
  assign pcnt_o = pcnt_q;
  assign busy_o = (state_q == StHold) || (state_q == StCapture);
  assign done_o = (state_q == StFin);

endmodule
